ex_issue_ctl: RTL



---
 rtl/ex_issue_ctl.sv | 93 +++++++++
 1 files changed

// File: rtl/ex_issue_ctl.sv
// ID/EX pipeline register with a DIVU sequencer: captures decode operands every
// cycle, and while a DIVU sits in EX it freezes itself and counts divider cycles.
module ex_issue_ctl #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [1:0]  id_ALUOp,
  input  logic [31:0] id_dataA,
  input  logic [31:0] id_dataB,
  input  logic [5:0]  id_Funct,
  input  logic [4:0]  id_extend_SHT,
  input  logic [4:0]  id_rd,
  input  logic        id_RegWrite,
  input  logic        id_flush,
  output logic [1:0]  ALUOp,
  output logic [31:0] dataA,
  output logic [31:0] dataB,
  output logic [5:0]  Funct,
  output logic [4:0]  extend_SHT,
  output logic [6:0]  total,
  output logic [4:0]  ex_rd,
  output logic        ex_RegWrite,
  output logic        ex_valid,
  output logic        stall,
  output logic        div_busy
);

  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] DIV        = 1'b1;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [6:0] TOTAL_LAST  = 7'(DIV_CYCLES);

  if (DIV_CYCLES < 1 || DIV_CYCLES > 126) begin : g_bad_div_cycles
    $error("ex_issue_ctl: DIV_CYCLES must be in 1..126");
  end

  logic [0:0] state;
  logic       is_div_id;

  assign is_div_id = id_valid && (id_ALUOp == ALUOP_RTYPE) && (id_Funct == FUNCT_DIVU);

  // Derived only from state and total so the front-end stall never depends on ID timing.
  assign div_busy = (state == DIV);
  assign stall    = div_busy && (total != TOTAL_LAST);

  // NOTE: every register here is sequential state, so it is written with <= only;
  // blocking assignments would let later statements see half-updated values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      total       <= '0;
      ALUOp       <= '0;
      dataA       <= '0;
      dataB       <= '0;
      Funct       <= '0;
      extend_SHT  <= '0;
      ex_rd       <= '0;
      ex_RegWrite <= 1'b0;
      ex_valid    <= 1'b0;
    end else if (stall) begin
      // Divide in progress: EX contents hold, ID is held upstream, flush is ignored.
      total <= total + 7'd1;
    end else begin
      total <= '0;
      if (id_flush) begin
        state       <= IDLE;
        ALUOp       <= '0;
        dataA       <= '0;
        dataB       <= '0;
        Funct       <= '0;
        extend_SHT  <= '0;
        ex_rd       <= '0;
        ex_RegWrite <= 1'b0;
        ex_valid    <= 1'b0;
      end else begin
        state       <= is_div_id ? DIV : IDLE;
        ALUOp       <= id_ALUOp;
        dataA       <= id_dataA;
        dataB       <= id_dataB;
        Funct       <= id_Funct;
        extend_SHT  <= id_extend_SHT;
        ex_rd       <= id_rd;
        // DIVU results go to HI/LO, never to the register file.
        ex_RegWrite <= id_RegWrite && !is_div_id;
        ex_valid    <= id_valid;
      end
    end
  end

endmodule
